// File: rtl/grid_ctrl.sv
// Grid cell-state owner: serialises a clear sweep, user clicks and engine writes
// into one flat cell vector, changing at most one cell per clock.
module grid_ctrl #(
  parameter int SIZE_X    = 10,
  parameter int SIZE_Y    = 10,
  parameter int CELL_BITS = 1,
  parameter int XBITS     = $clog2(SIZE_X),
  parameter int YBITS     = $clog2(SIZE_Y),
  parameter int GDBITS    = CELL_BITS * SIZE_X * SIZE_Y
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_req,
  output logic                 clr_done,
  output logic                 busy,
  input  logic                 click,
  input  logic                 click_inside,
  input  logic [XBITS-1:0]     click_x,
  input  logic [YBITS-1:0]     click_y,
  output logic                 click_drop,
  input  logic                 eng_valid,
  output logic                 eng_ready,
  input  logic [XBITS-1:0]     eng_x,
  input  logic [YBITS-1:0]     eng_y,
  input  logic [CELL_BITS-1:0] eng_type,
  output logic [GDBITS-1:0]    data
);

  localparam int NCELLS = SIZE_X * SIZE_Y;
  localparam int AW     = $clog2(GDBITS + 1);
  localparam int CW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [CW-1:0]  LAST_CELL = CW'(NCELLS - 1);
  localparam logic [XBITS:0] X_LIM     = (XBITS + 1)'(SIZE_X);
  localparam logic [YBITS:0] Y_LIM     = (YBITS + 1)'(SIZE_Y);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  typedef enum logic {GRANT_ENGINE = 1'b0, GRANT_CLICK = 1'b1} grant_t;

  state_t                 state, state_nx;
  grant_t                 last_grant;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   done_nx;
  logic                   click_pend;
  logic [XBITS-1:0]       pend_x;
  logic [YBITS-1:0]       pend_y;
  logic                   idle, eng_fire, click_grant;
  logic                   eng_in_range, click_ok, slot_free;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [CELL_BITS-1:0]   wr_val;

  // Coordinates are range-checked before use, so truncation to AW bits is safe.
  function automatic logic [AW-1:0] cell_addr(input logic [XBITS-1:0] x,
                                              input logic [YBITS-1:0] y);
    return (AW'(y) * AW'(SIZE_X) + AW'(x)) * AW'(CELL_BITS);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      clr_done <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST_CELL) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);
  assign idle = (state == IDLE);

  // The engine is held off only when the click would win the round-robin.
  assign eng_ready    = idle & ~clr_req & (~click_pend | (last_grant == GRANT_CLICK));
  assign eng_fire     = eng_valid & eng_ready;
  assign click_grant  = idle & click_pend & ~eng_fire;
  assign eng_in_range = ({1'b0, eng_x} < X_LIM) && ({1'b0, eng_y} < Y_LIM);
  assign click_ok     = click & click_inside &
                        ({1'b0, click_x} < X_LIM) & ({1'b0, click_y} < Y_LIM);
  assign slot_free    = ~click_pend | click_grant;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_val  = '0;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = AW'(cnt) * AW'(CELL_BITS);
    end else if (eng_fire && eng_in_range) begin
      wr_en   = 1'b1;
      wr_addr = cell_addr(eng_x, eng_y);
      wr_val  = eng_type;
    end else if (click_grant) begin
      wr_en   = 1'b1;
      wr_addr = cell_addr(pend_x, pend_y);
      wr_val  = data[wr_addr +: CELL_BITS] + CELL_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (wr_en) begin
      data[wr_addr +: CELL_BITS] <= wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_ENGINE;
    end else if (eng_fire) begin
      last_grant <= GRANT_ENGINE;
    end else if (click_grant) begin
      last_grant <= GRANT_CLICK;
    end
  end

  // A slot being drained this edge can accept a new click without dropping it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      click_pend <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      click_drop <= 1'b0;
    end else begin
      click_drop <= click_ok & ~slot_free;
      if (click_ok && slot_free) begin
        click_pend <= 1'b1;
        pend_x     <= click_x;
        pend_y     <= click_y;
      end else if (click_grant) begin
        click_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grid_ctrl.sv
// Scoreboard bench for grid_ctrl: a cell-array reference model predicts every
// cycle's outputs; separate monitors pop and compare them against the DUT.
module tb_grid_ctrl;

  localparam int SX     = 10;
  localparam int SY     = 10;
  localparam int CB     = 1;
  localparam int XB     = 4;
  localparam int YB     = 4;
  localparam int NCELLS = SX * SY;
  localparam int GD     = NCELLS * CB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_req = 1'b0;
  logic          clr_done;
  logic          busy;
  logic          click = 1'b0;
  logic          click_inside = 1'b0;
  logic [XB-1:0] click_x = '0;
  logic [YB-1:0] click_y = '0;
  logic          click_drop;
  logic          eng_valid = 1'b0;
  logic          eng_ready;
  logic [XB-1:0] eng_x = '0;
  logic [YB-1:0] eng_y = '0;
  logic [CB-1:0] eng_type = '0;
  logic [GD-1:0] data;

  always #5 clk = ~clk;

  grid_ctrl #(.SIZE_X(SX), .SIZE_Y(SY), .CELL_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .click(click), .click_inside(click_inside), .click_x(click_x), .click_y(click_y),
    .click_drop(click_drop), .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_x(eng_x), .eng_y(eng_y), .eng_type(eng_type), .data(data)
  );

  typedef struct {
    logic [GD-1:0] data;
    logic          busy;
    logic          done;
    logic          drop;
  } exp_t;

  exp_t state_q[$];
  logic ready_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model: a 2-D cell array, one pending-click slot, who won last,
  // and the sweep position (-1 when no clear is running).
  int cells[SY][SX];
  bit pend;
  int px, py;
  bit last_click;
  int sweep;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [GD-1:0] modelData();
    logic [GD-1:0] d = '0;
    for (int y = 0; y < SY; y++)
      for (int x = 0; x < SX; x++)
        d[(y * SX + x) * CB +: CB] = CB'(cells[y][x]);
    return d;
  endfunction

  task automatic modelReset();
    for (int y = 0; y < SY; y++)
      for (int x = 0; x < SX; x++)
        cells[y][x] = 0;
    pend = 0; px = 0; py = 0; last_click = 0; sweep = -1;
  endtask

  task automatic applyStimulus(input bit cr, input bit ck, input bit ins, input int cx, input int cy,
                               input bit ev, input int ex, input int ey, input int et, output bit rdy);
    bit   idle, fire, capply, ok;
    exp_t e;
    @(negedge clk);
    clr_req = cr; click = ck; click_inside = ins;
    click_x = XB'(cx); click_y = YB'(cy);
    eng_valid = ev; eng_x = XB'(ex); eng_y = YB'(ey); eng_type = CB'(et);

    idle   = (sweep < 0);
    rdy    = idle && !cr && (!pend || last_click);
    fire   = ev && rdy;
    capply = idle && pend && !fire;
    e.done = 1'b0;
    if (!idle) begin
      cells[sweep / SX][sweep % SX] = 0;
      if (sweep == NCELLS - 1) begin
        sweep  = -1;
        e.done = 1'b1;
      end else begin
        sweep++;
      end
    end else begin
      if (fire) begin
        if (ex < SX && ey < SY) cells[ey][ex] = et % (1 << CB);
        last_click = 0;
      end else if (capply) begin
        cells[py][px] = (cells[py][px] + 1) % (1 << CB);
        last_click = 1;
      end
      if (cr) sweep = 0;
    end
    if (capply) pend = 0;
    ok     = ck && ins && cx < SX && cy < SY;
    e.drop = 1'b0;
    if (ok) begin
      if (!pend) begin
        pend = 1; px = cx; py = cy;
      end else begin
        e.drop = 1'b1;
      end
    end
    e.data = modelData();
    e.busy = (sweep >= 0);
    ready_q.push_back(rdy);
    state_q.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    bit r;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, r);
  endtask

  initial begin : state_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        checkOutput("data", data, e.data);
        checkOutput("busy", busy, e.busy);
        checkOutput("clr_done", clr_done, e.done);
        checkOutput("click_drop", click_drop, e.drop);
      end
    end
  end

  initial begin : ready_monitor
    forever begin
      @(negedge clk);
      #1;
      if (ready_q.size() > 0) checkOutput("eng_ready", eng_ready, ready_q.pop_front());
    end
  end

  initial begin : main
    bit r, ev, hold, cr, ck, ins;
    int ex, ey, et, cx, cy;
    modelReset();
    #2;
    checkOutput("reset_data", data, '0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_clr_done", clr_done, 1'b0);
    checkOutput("reset_click_drop", click_drop, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single engine write lands on bit 23.
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 2, 1, r);
    @(posedge clk);
    #2 checkOutput("t1_bit23", data[23], 1'b1);

    // Same cell clicked twice toggles it back.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, r);
    idleCycles(4);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, r);
    idleCycles(3);

    // Contention in both round-robin orders.
    applyStimulus(0, 1, 1, 1, 1, 0, 0, 0, 0, r);
    applyStimulus(0, 0, 0, 0, 0, 1, 2, 2, 1, r);
    applyStimulus(0, 0, 0, 0, 0, 1, 2, 2, 1, r);
    applyStimulus(0, 1, 1, 6, 6, 0, 0, 0, 0, r);
    applyStimulus(0, 1, 1, 8, 1, 0, 0, 0, 0, r);
    applyStimulus(0, 0, 0, 0, 0, 1, 9, 0, 1, r);
    idleCycles(3);

    // Fill cells, then clear with the engine waiting and two clicks arriving.
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, 0, 0, 0, 1, $urandom_range(0, SX - 1), $urandom_range(0, SY - 1), 1, r);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, r);
    hold = 1;
    for (int i = 0; i < 105; i++) begin
      applyStimulus(0, (i == 10 || i == 20), 1, 7, 3, hold, 4, 4, 1, r);
      if (hold && r) hold = 0;
    end
    idleCycles(2);

    // Reset in the middle of a sweep.
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 7, 1, r);
    applyStimulus(0, 0, 0, 0, 0, 1, 9, 9, 1, r);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, r);
    idleCycles(40);
    @(negedge clk);
    #2 rst_n = 1'b0;
    clr_req = 0; click = 0; click_inside = 0; eng_valid = 0;
    #1;
    checkOutput("async_rst_data", data, '0);
    checkOutput("async_rst_busy", busy, 1'b0);
    modelReset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idleCycles(2);

    // Randomised traffic; the engine holds its payload until accepted.
    ev = 0; ex = 0; ey = 0; et = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ev) begin
        ev = ($urandom_range(0, 2) != 0);
        ex = $urandom_range(0, 11);
        ey = $urandom_range(0, 11);
        et = $urandom_range(0, 1);
      end
      cr  = ($urandom_range(0, 59) == 0);
      ck  = ($urandom_range(0, 3) == 0);
      ins = ($urandom_range(0, 7) != 0);
      cx  = $urandom_range(0, 15);
      cy  = $urandom_range(0, 15);
      applyStimulus(cr, ck, ins, cx, cy, ev, ex, ey, et, r);
      if (ev && r) ev = 0;
    end

    for (int i = 0; i < 10 && (state_q.size() + ready_q.size()) > 0; i++) @(posedge clk);
    #2;
    checkOutput("queue_drain", 128'(state_q.size() + ready_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
